// File: rtl/bg_pattern_gen.sv
// VGA background generator: solid, frame+brackets, colour matrix, gradient band.
// Define BG_SCROLL_EN to compile in the frame-synchronous gradient scroll.
module bg_pattern_gen #(
  parameter int XFRAME          = 635,
  parameter int YFRAME          = 475,
  parameter int BRACKET_OFFSET  = 30,
  parameter int MATRIX_LEFT_X   = 100,
  parameter int MATRIX_TOP_Y    = 100,
  parameter int CELL_LOG2       = 3,
  parameter int GRAD_TOP_Y      = 8,
  parameter int SCROLL_DIV_LOG2 = 2,
  parameter int SCROLL_STEP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [1:0]  mode,
  input  logic [7:0]  solidColor,
  output logic [7:0]  BG_RGB,
  output logic        boardersDrawReq,
  output logic        frameStart
);

  localparam logic [10:0] LP_BL  = 11'(BRACKET_OFFSET);
  localparam logic [10:0] LP_BR  = 11'(XFRAME - BRACKET_OFFSET);
  localparam logic [10:0] LP_BB  = 11'(YFRAME - BRACKET_OFFSET);
  localparam logic [10:0] LP_XF  = 11'(XFRAME);
  localparam logic [10:0] LP_YF  = 11'(YFRAME);
  localparam logic [10:0] LP_MX0 = 11'(MATRIX_LEFT_X);
  localparam logic [10:0] LP_MX1 = 11'(MATRIX_LEFT_X + (16 << CELL_LOG2));
  localparam logic [10:0] LP_MY0 = 11'(MATRIX_TOP_Y);
  localparam logic [10:0] LP_MY1 = 11'(MATRIX_TOP_Y + (16 << CELL_LOG2));
  localparam logic [10:0] LP_GY0 = 11'(GRAD_TOP_Y);
  localparam logic [10:0] LP_GY1 = 11'(GRAD_TOP_Y + 16);

  logic        w_zero;
  logic        w_fs;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_cx;
  logic [10:0] w_cy;
  logic [10:0] w_xs;
  logic        w_unused;

  logic        r_prevZero;
  logic [1:0]  r_modeR;
  logic [7:0]  r_solidR;

  logic        r1_fs;
  logic        r1_bracket;
  logic        r1_border;
  logic        r1_inMat;
  logic        r1_inBand;
  logic [3:0]  r1_col;
  logic [3:0]  r1_row;
  logic [7:0]  r1_grad;

  logic [7:0]  w_rgb;
  logic        w_req;
  logic [7:0]  r2_rgb;
  logic        r2_req;
  logic        r2_fs;

  assign w_zero = (pixelX == '0) && (pixelY == '0);
  assign w_fs   = w_zero && !r_prevZero;

  assign w_dx = pixelX - LP_MX0;
  assign w_dy = pixelY - LP_MY0;
  assign w_cx = w_dx >> CELL_LOG2;
  assign w_cy = w_dy >> CELL_LOG2;

`ifdef BG_SCROLL_EN
  localparam logic [SCROLL_DIV_LOG2-1:0] LP_ONE = 1;

  logic [SCROLL_DIV_LOG2-1:0] r_frameCnt;
  logic [10:0]                r_scroll;

  // scroll advances on the frame start that wraps the frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameCnt <= '0;
      r_scroll   <= '0;
    end else if (w_fs) begin
      r_frameCnt <= r_frameCnt + LP_ONE;
      if (r_frameCnt == '1)
        r_scroll <= r_scroll + 11'(SCROLL_STEP);
    end
  end

  assign w_xs = pixelX + r_scroll;
`else
  assign w_xs = pixelX;
`endif

  assign w_unused = &{1'b0, w_cx, w_cy, w_xs};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prevZero <= 1'b0;
      r_modeR    <= 2'd0;
      r_solidR   <= 8'h00;
    end else begin
      r_prevZero <= w_zero;
      if (w_fs) begin
        r_modeR  <= mode;
        r_solidR <= solidColor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_fs      <= 1'b0;
      r1_bracket <= 1'b0;
      r1_border  <= 1'b0;
      r1_inMat   <= 1'b0;
      r1_inBand  <= 1'b0;
      r1_col     <= '0;
      r1_row     <= '0;
      r1_grad    <= '0;
    end else begin
      r1_fs      <= w_fs;
      r1_bracket <= (pixelX == LP_BL) || (pixelY == LP_BL) ||
                    (pixelX == LP_BR) || (pixelY == LP_BB);
      r1_border  <= (pixelX == '0) || (pixelY == '0) ||
                    (pixelX == LP_XF) || (pixelY == LP_YF);
      r1_inMat   <= (pixelX >= LP_MX0) && (pixelX < LP_MX1) &&
                    (pixelY >= LP_MY0) && (pixelY < LP_MY1);
      r1_inBand  <= (pixelY >= LP_GY0) && (pixelY < LP_GY1);
      r1_col     <= w_cx[3:0];
      r1_row     <= w_cy[3:0];
      r1_grad    <= {w_xs[8:6], w_xs[5:3], w_xs[2:1]};
    end
  end

  // modeR here already holds the value latched for the pixel in stage 1
  always_comb begin
    w_rgb = r_solidR;
    w_req = 1'b0;
    unique case (r_modeR)
      2'd0: w_rgb = r_solidR;
      2'd1: begin
        if (r1_bracket) begin
          w_rgb = 8'hFF;
          w_req = 1'b1;
        end else if (r1_border) begin
          w_rgb = 8'hFC;
        end else begin
          w_rgb = 8'h00;
        end
      end
      2'd2: begin
        if (r1_inMat)
          w_rgb = {r1_col[2:0], r1_row[2:0], r1_col[3], r1_row[3]};
      end
      2'd3: begin
        if (r1_inBand)
          w_rgb = r1_grad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r2_rgb <= 8'h00;
      r2_req <= 1'b0;
      r2_fs  <= 1'b0;
    end else begin
      r2_rgb <= w_rgb;
      r2_req <= w_req;
      r2_fs  <= r1_fs;
    end
  end

  assign BG_RGB          = r2_rgb;
  assign boardersDrawReq = r2_req;
  assign frameStart      = r2_fs;

endmodule
